set_assoc_cache: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate data cache with true-LRU replacement.
- Sits between the pipeline memory stage and the line-granular data memory. Generalises the direct-mapped cache to arbitrary ways, sets and line size.
- Replaces combinational/latch-style control with a single clocked FSM.
- Exposes the memory-side handshake as ports, so the bench can model arbitrary memory latency.

---
 rtl/set_assoc_cache.sv | 177 +++++++++++++++++
 tb/tb_set_assoc_cache.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative write-back, write-allocate data cache with true-LRU replacement
module set_assoc_cache #(
    parameter int LINE_SIZE = 16,
    parameter int NUM_SETS  = 2,
    parameter int NUM_WAYS  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   is_input_valid,
    input  logic [31:0]            addr,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            din,
    output logic                   is_ready,
    output logic                   is_output_valid,
    output logic [31:0]            dout,
    output logic                   is_hit,
    output logic                   dm_is_input_valid,
    output logic [31:0]            dm_addr,
    output logic                   dm_mem_read,
    output logic                   dm_mem_write,
    output logic [LINE_SIZE*8-1:0] dm_din,
    input  logic                   dm_is_output_valid,
    input  logic [LINE_SIZE*8-1:0] dm_dout,
    input  logic                   dm_ready
);
    localparam int OFF = $clog2(LINE_SIZE);
    localparam int IDX = $clog2(NUM_SETS);
    localparam int TW  = 32 - OFF - IDX;
    localparam int AW  = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
    localparam int IW  = IDX > 0 ? IDX : 1;
    localparam int WW  = OFF > 2 ? OFF - 2 : 1;
    localparam int LB  = LINE_SIZE * 8;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] COMPARE   = 3'd1;
    localparam logic [2:0] WB_REQ    = 3'd2;
    localparam logic [2:0] FILL_REQ  = 3'd3;
    localparam logic [2:0] FILL_WAIT = 3'd4;

    logic [2:0]    state;
    logic [31:0]   req_addr;
    logic [31:0]   req_din;
    logic          req_write;
    logic          first_hit;
    logic [AW-1:0] victim;

    logic          valid [NUM_SETS][NUM_WAYS];
    logic          dirty [NUM_SETS][NUM_WAYS];
    logic [AW-1:0] age   [NUM_SETS][NUM_WAYS];
    logic [TW-1:0] tags  [NUM_SETS][NUM_WAYS];
    logic [LB-1:0] data  [NUM_SETS][NUM_WAYS];

    logic [IW-1:0] set_idx;
    logic [WW-1:0] wsel;
    logic [TW-1:0] req_tag;
    logic          hit;
    logic [AW-1:0] hit_way;
    logic [AW-1:0] vic_way;
    logic          found_inv;

    assign req_tag  = req_addr[31:OFF+IDX];
    assign is_ready = (state == IDLE) && !reset;

    if (IDX > 0) begin : g_idx
        assign set_idx = req_addr[OFF+IDX-1:OFF];
    end else begin : g_noidx
        assign set_idx = '0;
    end

    if (OFF > 2) begin : g_wsel
        assign wsel = req_addr[OFF-1:2];
    end else begin : g_nowsel
        assign wsel = '0;
    end

    // Tag lookup in the addressed set, plus replacement choice: first invalid way, else the oldest
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        vic_way = '0;
        found_inv = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[set_idx][w] && tags[set_idx][w] == req_tag && !hit) begin
                hit = 1'b1;
                hit_way = AW'(w);
            end
            if (!valid[set_idx][w] && !found_inv) begin
                found_inv = 1'b1;
                vic_way = AW'(w);
            end
        end
        if (!found_inv)
            for (int w = 0; w < NUM_WAYS; w++)
                if (age[set_idx][w] == AW'(NUM_WAYS - 1))
                    vic_way = AW'(w);
    end

    // Request acceptance, hit completion, write-back/refill sequencing and LRU upkeep
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            is_output_valid <= 1'b0;
            is_hit <= 1'b0;
            dout <= '0;
            dm_is_input_valid <= 1'b0;
            dm_mem_read <= 1'b0;
            dm_mem_write <= 1'b0;
            dm_addr <= '0;
            dm_din <= '0;
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    age[s][w] <= '0;
                end
        end else begin
            is_output_valid <= 1'b0;
            dm_is_input_valid <= 1'b0;
            dm_mem_read <= 1'b0;
            dm_mem_write <= 1'b0;
            dm_addr <= '0;
            dm_din <= '0;
            case (state)
                IDLE: if (is_input_valid && (mem_read ^ mem_write)) begin
                    req_addr <= addr;
                    req_din <= din;
                    req_write <= mem_write;
                    first_hit <= 1'b1;
                    state <= COMPARE;
                end
                COMPARE: if (hit) begin
                    if (req_write) begin
                        data[set_idx][hit_way][32*wsel +: 32] <= req_din;
                        dirty[set_idx][hit_way] <= 1'b1;
                    end else
                        dout <= data[set_idx][hit_way][32*wsel +: 32];
                    for (int w = 0; w < NUM_WAYS; w++)
                        if (AW'(w) == hit_way)
                            age[set_idx][w] <= '0;
                        else if (age[set_idx][w] < age[set_idx][hit_way])
                            age[set_idx][w] <= age[set_idx][w] + 1'b1;
                    is_output_valid <= 1'b1;
                    is_hit <= first_hit;
                    state <= IDLE;
                end else begin
                    first_hit <= 1'b0;
                    victim <= vic_way;
                    state <= (valid[set_idx][vic_way] && dirty[set_idx][vic_way]) ? WB_REQ : FILL_REQ;
                end
                WB_REQ: if (dm_ready) begin
                    dm_is_input_valid <= 1'b1;
                    dm_mem_write <= 1'b1;
                    dm_addr <= (32'(tags[set_idx][victim]) << (OFF + IDX)) | (32'(set_idx) << OFF);
                    dm_din <= data[set_idx][victim];
                    state <= FILL_REQ;
                end
                FILL_REQ: if (dm_ready) begin
                    dm_is_input_valid <= 1'b1;
                    dm_mem_read <= 1'b1;
                    dm_addr <= req_addr & ~32'(LINE_SIZE - 1);
                    state <= FILL_WAIT;
                end
                FILL_WAIT: if (dm_is_output_valid) begin
                    data[set_idx][victim] <= dm_dout;
                    tags[set_idx][victim] <= req_tag;
                    valid[set_idx][victim] <= 1'b1;
                    dirty[set_idx][victim] <= 1'b0;
                    // A refilled way enters as the oldest so the hit that follows ages the others correctly
                    age[set_idx][victim] <= AW'(NUM_WAYS - 1);
                    state <= COMPARE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: scoreboard bench for the 2-way/16B default cache and a 4-way/4-set/32B instance
module tb_set_assoc_cache;
    typedef struct {
        logic [31:0] d;
        logic        h;
        logic        cd;
        int          lat;
        int          t;
    } exp_t;
    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d0;
    } dmx_t;

    logic clk = 0, reset = 1, sel = 0;
    logic iv, rd, wr, dm_ready, dm_ov;
    logic [31:0] addr, din;
    logic [255:0] dm_dout;
    logic r0, ov0, h0, dmiv0, dmrd0, dmwr0;
    logic [31:0] dout0, dmaddr0;
    logic [127:0] dmdin0;
    logic r1, ov1, h1, dmiv1, dmrd1, dmwr1;
    logic [31:0] dout1, dmaddr1;
    logic [255:0] dmdin1;
    logic ready, ov, hit, dmiv, dmrd, dmwr;
    logic [31:0] dout, dmaddr;
    logic [255:0] dmdin;

    exp_t exp_q[$];
    dmx_t dm_q[$];
    logic [255:0] mem [logic [31:0]];
    logic [31:0] la;
    int total = 0, bad = 0, cyc = 0, out_cnt = 0, dm_cnt = 0, lat = 5;

    set_assoc_cache dut (
        .clk(clk), .reset(reset), .is_input_valid(iv & ~sel), .addr(addr),
        .mem_read(rd), .mem_write(wr), .din(din), .is_ready(r0),
        .is_output_valid(ov0), .dout(dout0), .is_hit(h0),
        .dm_is_input_valid(dmiv0), .dm_addr(dmaddr0), .dm_mem_read(dmrd0),
        .dm_mem_write(dmwr0), .dm_din(dmdin0), .dm_is_output_valid(dm_ov & ~sel),
        .dm_dout(dm_dout[127:0]), .dm_ready(dm_ready)
    );

    set_assoc_cache #(.LINE_SIZE(32), .NUM_SETS(4), .NUM_WAYS(4)) dut4 (
        .clk(clk), .reset(reset), .is_input_valid(iv & sel), .addr(addr),
        .mem_read(rd), .mem_write(wr), .din(din), .is_ready(r1),
        .is_output_valid(ov1), .dout(dout1), .is_hit(h1),
        .dm_is_input_valid(dmiv1), .dm_addr(dmaddr1), .dm_mem_read(dmrd1),
        .dm_mem_write(dmwr1), .dm_din(dmdin1), .dm_is_output_valid(dm_ov & sel),
        .dm_dout(dm_dout), .dm_ready(dm_ready)
    );

    assign ready  = sel ? r1 : r0;
    assign ov     = sel ? ov1 : ov0;
    assign hit    = sel ? h1 : h0;
    assign dout   = sel ? dout1 : dout0;
    assign dmiv   = sel ? dmiv1 : dmiv0;
    assign dmrd   = sel ? dmrd1 : dmrd0;
    assign dmwr   = sel ? dmwr1 : dmwr0;
    assign dmaddr = sel ? dmaddr1 : dmaddr0;
    assign dmdin  = sel ? dmdin1 : {128'b0, dmdin0};

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = a + 32'(4 * i);
        return l;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic dmx(input logic w, input logic [31:0] a, input logic [31:0] d0);
        dm_q.push_back('{w, a, d0});
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] ed, input logic eh, input logic cd, input logic eo);
        int n = 0;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 1);
        if (eo) exp_q.push_back('{ed, eh, cd, eh ? 2 : 0, cyc});
        addr = a;
        din = d;
        rd = !w;
        wr = w;
        iv = 1;
        @(negedge clk);
        iv = 0;
        rd = 0;
        wr = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || dm_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending out=%0d dm=%0d, required 0", exp_q.size(), dm_q.size());
        end
    endtask

    // Memory model: stores write-backs, answers fills after lat cycles
    initial begin
        dm_ov = 0;
        dm_dout = '0;
        forever begin
            @(negedge clk);
            if (!reset && dmiv) begin
                if (dmwr) mem[dmaddr] = dmdin;
                else begin
                    la = dmaddr;
                    repeat (lat) @(negedge clk);
                    dm_dout = mem.exists(la) ? mem[la] : pat(la);
                    dm_ov = 1;
                    @(negedge clk);
                    dm_ov = 0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the selected cache completes or strobes memory
    initial begin
        exp_t e;
        dmx_t x;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ov) begin
                    out_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: dout=%h hit=%b, required no pulse", dout, hit);
                    end else begin
                        e = exp_q.pop_front();
                        chk("is_hit", 32'(hit), 32'(e.h));
                        if (e.cd) chk("dout", dout, e.d);
                        if (e.lat != 0) chk("hit_latency", 32'(cyc - e.t), 32'(e.lat));
                    end
                end
                if (dmiv) begin
                    dm_cnt++;
                    if (dm_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_dm: addr=%h rd=%b wr=%b, required no strobe", dmaddr, dmrd, dmwr);
                    end else begin
                        x = dm_q.pop_front();
                        chk("dm_op", {30'b0, dmwr, dmrd}, {30'b0, x.w, !x.w});
                        chk("dm_addr", dmaddr, x.a);
                        if (x.w) chk("dm_wb_word0", dmdin[31:0], x.d0);
                    end
                end
            end
        end
    end

    initial begin
        int n, n0, c0;
        logic [31:0] fills [4] = '{32'h020, 32'h0A0, 32'h120, 32'h1A0};
        logic [31:0] hits [3] = '{32'h024, 32'h0A8, 32'h12C};
        iv = 0;
        rd = 0;
        wr = 0;
        addr = 0;
        din = 0;
        dm_ready = 1;
        mem[32'h10] = {128'b0, 32'd4, 32'd3, 32'd2, 32'd1};
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 32'(ready), 0);
        reset = 0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_out_valid", 32'(ov), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_dout", dout, 0);
        chk("rst_dm_strobe", {29'b0, dmiv, dmrd, dmwr}, 0);
        chk("rst_dm_addr", dmaddr, 0);
        chk("rst_dm_din", 32'(|dmdin), 0);

        dmx(0, 32'h10, 0);
        req(32'h10, 0, 0, 32'd1, 0, 1, 1);
        drain();
        req(32'h1C, 0, 0, 32'd4, 1, 1, 1);
        drain();

        dmx(0, 32'h00, 0);
        req(32'h00, 1, 32'hDEADBEEF, 0, 0, 0, 1);
        drain();
        dmx(0, 32'h40, 0);
        req(32'h40, 0, 0, 32'h40, 0, 1, 1);
        drain();
        dmx(1, 32'h00, 32'hDEADBEEF);
        dmx(0, 32'h80, 0);
        req(32'h80, 0, 0, 32'h80, 0, 1, 1);
        drain();
        dmx(0, 32'h00, 0);
        req(32'h00, 0, 0, 32'hDEADBEEF, 0, 1, 1);
        drain();

        req(32'h00, 0, 0, 32'hDEADBEEF, 1, 1, 1);
        drain();
        dmx(0, 32'h40, 0);
        req(32'h40, 0, 0, 32'h40, 0, 1, 1);
        drain();
        req(32'h00, 0, 0, 32'hDEADBEEF, 1, 1, 1);
        drain();
        dmx(0, 32'h80, 0);
        req(32'h80, 0, 0, 32'h80, 0, 1, 1);
        drain();
        req(32'h00, 0, 0, 32'hDEADBEEF, 1, 1, 1);
        drain();
        req(32'h80, 1, 32'h12345678, 0, 1, 0, 1);
        drain();
        req(32'h80, 0, 0, 32'h12345678, 1, 1, 1);
        drain();
        req(32'h00, 0, 0, 32'hDEADBEEF, 1, 1, 1);
        drain();

        n0 = out_cnt;
        c0 = dm_cnt;
        addr = 32'h10;
        rd = 1;
        wr = 1;
        iv = 1;
        @(negedge clk);
        rd = 0;
        wr = 0;
        @(negedge clk);
        iv = 0;
        repeat (6) @(negedge clk);
        chk("bad_op_no_output", 32'(out_cnt), 32'(n0));
        chk("bad_op_no_dm", 32'(dm_cnt), 32'(c0));
        chk("bad_op_ready", 32'(ready), 1);

        n0 = out_cnt;
        dmx(1, 32'h80, 32'h12345678);
        dmx(0, 32'h100, 0);
        req(32'h100, 0, 0, 32'h100, 0, 1, 1);
        chk("busy_not_ready", 32'(ready), 0);
        addr = 32'h10;
        rd = 1;
        iv = 1;
        repeat (2) @(negedge clk);
        iv = 0;
        rd = 0;
        drain();
        repeat (3) @(negedge clk);
        chk("busy_req_ignored", 32'(out_cnt), 32'(n0 + 1));

        n0 = out_cnt;
        c0 = dm_cnt;
        dmx(0, 32'h200, 0);
        req(32'h200, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (dm_cnt == c0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_fill_issued", 32'(dm_cnt), 32'(c0 + 1));
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        repeat (10) @(negedge clk);
        chk("abort_no_output", 32'(out_cnt), 32'(n0));
        chk("abort_ready", 32'(ready), 1);
        dmx(0, 32'h200, 0);
        req(32'h200, 0, 0, 32'h200, 0, 1, 1);
        drain();

        sel = 1;
        lat = 2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dmx(0, fills[i], 0);
            req(fills[i], 0, 0, fills[i], 0, 1, 1);
            drain();
        end
        for (int i = 0; i < 3; i++) begin
            req(hits[i], 0, 0, hits[i], 1, 1, 1);
            drain();
        end
        dmx(0, 32'h220, 0);
        req(32'h234, 0, 0, 32'h234, 0, 1, 1);
        drain();
        req(32'h020, 0, 0, 32'h020, 1, 1, 1);
        drain();
        dmx(0, 32'h1A0, 0);
        req(32'h1AC, 0, 0, 32'h1AC, 0, 1, 1);
        drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
